// File: rtl/image_streamer_pkg.sv
// -----------------------------------------------------------------------------
// image_streamer_pkg
// Constants shared between image_streamer and the Conv2D front end, plus the
// streamer's FSM state type.
//   filterSize : convolution kernel edge length
//   sizeLB     : Conv2D line-buffer depth for a 28-pixel-wide frame
//   PIXEL_W    : pixel width; must match the Conv2D `data` width
// -----------------------------------------------------------------------------
package image_streamer_pkg;

  localparam int filterSize = 3;
  localparam int sizeLB     = (filterSize - 1) * 28 + filterSize;
  localparam int PIXEL_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STREAM = 2'b01,
    DONE   = 2'b10
  } state_e;

endpackage

// File: rtl/image_streamer_if.sv
// -----------------------------------------------------------------------------
// image_streamer_if
// Load port, start control and pixel stream of image_streamer.
//   load_en/load_addr/load_data : image RAM write port (honoured in IDLE only)
//   start                       : single-cycle frame start
//   data_in_en                  : consumer request, one pixel per high cycle
//   data/valid                  : pixel stream
//   busy/frame_done             : frame status
// Modports: master = consumer/loader side, slave = image_streamer.
// -----------------------------------------------------------------------------
interface image_streamer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
);
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              start;
  logic              data_in_en;
  logic [DATA_W-1:0] data;
  logic              valid;
  logic              busy;
  logic              frame_done;

  modport master (
    output load_en, load_addr, load_data, start, data_in_en,
    input  data, valid, busy, frame_done
  );

  modport slave (
    input  load_en, load_addr, load_data, start, data_in_en,
    output data, valid, busy, frame_done
  );
endinterface

// File: rtl/image_ram.sv
// -----------------------------------------------------------------------------
// image_ram
// Single-port-write, single-port synchronous-read frame store, 2^ADDR_W deep.
//   clk              : clock
//   we/waddr/wdata   : write port
//   re/raddr         : read request; rdata updates on the following edge
//   rdata            : read data, holds its value when re is low
// -----------------------------------------------------------------------------
module image_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage and read register carry no reset so the array maps onto
  // block RAM and the loaded frame survives a controller reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/image_streamer.sv
// -----------------------------------------------------------------------------
// image_streamer
// Raster-order pixel source for the Conv2D line buffer. A frame is loaded into
// image_ram while idle; after `start` one pixel is released per cycle in which
// data_in_en is high, with frame_done on the last pixel.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : image_streamer_if.slave (load port, start, stream, status)
// Build option: define STREAM_ZERO_PAD_EN to wrap the frame in a one-pixel
// zero border ((IMG_H+2)x(IMG_W+2) pixels) for "same"-size convolution.
// -----------------------------------------------------------------------------
module image_streamer
  import image_streamer_pkg::*;
#(
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int DATA_W = PIXEL_W,
  parameter int ADDR_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  image_streamer_if.slave bus
);

`ifdef STREAM_ZERO_PAD_EN
  localparam int LAST_ROW = IMG_H + 1;
  localparam int LAST_COL = IMG_W + 1;
`else
  localparam int LAST_ROW = IMG_H - 1;
  localparam int LAST_COL = IMG_W - 1;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] row_q, col_q;
  logic              valid_q;
  logic              consume;
  logic              last_pixel;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    consume    = 1'b0;
    last_pixel = (row_q == ADDR_W'(LAST_ROW)) && (col_q == ADDR_W'(LAST_COL));
    unique case (state_q)
      IDLE:   if (bus.start) state_d = STREAM;
      STREAM: if (bus.data_in_en) begin
                consume = 1'b1;
                if (last_pixel) state_d = DONE;
              end
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Counters only move on a consumed pixel, so a stall resumes in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= consume;
      if (state_q == IDLE && bus.start) begin
        row_q <= '0;
        col_q <= '0;
      end else if (consume) begin
        if (col_q == ADDR_W'(LAST_COL)) begin
          col_q <= '0;
          row_q <= row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

`ifdef STREAM_ZERO_PAD_EN
  logic border;
  logic pad_q;

  assign border = (row_q == '0) || (row_q == ADDR_W'(LAST_ROW)) ||
                  (col_q == '0) || (col_q == ADDR_W'(LAST_COL));
  // Padded coordinates are offset by one; border cells never read the RAM.
  assign rd_addr = (row_q - ADDR_W'(1)) * ADDR_W'(IMG_W) + (col_q - ADDR_W'(1));
  assign rd_en   = consume && !border;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pad_q <= 1'b0;
    else        pad_q <= consume && border;
  end

  assign bus.data = (valid_q && !pad_q) ? rd_data : '0;
`else
  assign rd_addr  = row_q * ADDR_W'(IMG_W) + col_q;
  assign rd_en    = consume;
  // RAM output is not reset; gating by valid gives data=0 out of reset.
  assign bus.data = valid_q ? rd_data : '0;
`endif

  image_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (state_q == IDLE && bus.load_en),
    .waddr (bus.load_addr),
    .wdata (bus.load_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // busy and frame_done are pure state decodes: busy spans STREAM..DONE and
  // DONE lasts exactly the cycle after the last pixel is consumed.
  assign bus.valid      = valid_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == DONE);

endmodule

// File: tb/tb_image_streamer.sv
// -----------------------------------------------------------------------------
// tb_image_streamer
// Directed bench for image_streamer with a 4x4 frame holding 1..16.
// Handles both the plain and the STREAM_ZERO_PAD_EN build.
// -----------------------------------------------------------------------------
module tb_image_streamer;

  localparam int W = 4;
  localparam int H = 4;
`ifdef STREAM_ZERO_PAD_EN
  localparam int FL = (W + 2) * (H + 2);
`else
  localparam int FL = W * H;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  image_streamer_if #(.DATA_W(16), .ADDR_W(10)) bus ();

  image_streamer #(
    .IMG_W (W), .IMG_H (H), .DATA_W (16), .ADDR_W (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en;
    logic        exp_valid;
    logic [15:0] exp_data;
    logic        exp_done;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [2*FL];

  // Expected pixel value for raster index k of a frame loaded with 1..16.
  function automatic logic [15:0] pix(input int k);
`ifdef STREAM_ZERO_PAD_EN
    int r, c;
    r = k / (W + 2);
    c = k % (W + 2);
    if (r == 0 || r == H + 1 || c == 0 || c == W + 1) return 16'd0;
    return 16'((r - 1) * W + (c - 1) + 1);
`else
    return 16'(k + 1);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " data"},       32'(bus.data),       32'd0);
    check({tag, " valid"},      32'(bus.valid),      32'd0);
    check({tag, " busy"},       32'(bus.busy),       32'd0);
    check({tag, " frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  // Writes 1..16; optionally raises start together with the final write.
  task automatic load_frame(input bit start_with_last);
    for (int a = 0; a < W * H; a++) begin
      bus.load_en   = 1'b1;
      bus.load_addr = 10'(a);
      bus.load_data = 16'(a + 1);
      bus.start     = start_with_last && (a == W * H - 1);
      step();
    end
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
  endtask

  // Streams a full frame with data_in_en held high; optionally pulses
  // start + load(addr 0 = 99) during the request of pixel disturb_at.
  task automatic run_frame(input bit skip_start, input int disturb_at);
    if (!skip_start) begin
      bus.start      = 1'b1;
      bus.data_in_en = 1'b0;
      step();
      bus.start = 1'b0;
      check("start busy",  32'(bus.busy),  32'd1);
      check("start valid", 32'(bus.valid), 32'd0);
    end
    bus.data_in_en = 1'b1;
    for (int k = 0; k < FL; k++) begin
      if (k == disturb_at) begin
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_addr = 10'd0;
        bus.load_data = 16'd99;
      end
      step();
      bus.start   = 1'b0;
      bus.load_en = 1'b0;
      check($sformatf("px%0d valid", k), 32'(bus.valid),      32'd1);
      check($sformatf("px%0d data", k),  32'(bus.data),       32'(pix(k)));
      check($sformatf("px%0d done", k),  32'(bus.frame_done), 32'(k == FL - 1));
      check($sformatf("px%0d busy", k),  32'(bus.busy),       32'd1);
    end
    bus.data_in_en = 1'b0;
    step();
    check_idle_outputs("post-frame");
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_addr  = '0;
    bus.load_data  = '0;
    bus.start      = 1'b0;
    bus.data_in_en = 1'b0;

    // Reset values.
    #2;
    check_idle_outputs("reset");
    #10 rst_n = 1'b1;

    // Load, with start coinciding with the final write; the new value at
    // addr 15 is read many cycles later, so it must be streamed.
    load_frame(1'b1);
    check("start+load busy", 32'(bus.busy), 32'd1);
    run_frame(1'b1, -1);

    // Alternating request: table of per-cycle stimulus and expectations.
    for (int i = 0; i < 2 * FL; i++) begin
      vecs[i].en        = (i % 2 == 0);
      vecs[i].exp_valid = (i % 2 == 0);
      vecs[i].exp_data  = (i % 2 == 0) ? pix(i / 2) : 16'd0;
      vecs[i].exp_done  = (i == 2 * FL - 2);
      vecs[i].exp_busy  = (i <= 2 * FL - 2);
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 2 * FL; i++) begin
      bus.data_in_en = vecs[i].en;
      step();
      check($sformatf("tog%0d valid", i), 32'(bus.valid),      32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        check($sformatf("tog%0d data", i), 32'(bus.data),     32'(vecs[i].exp_data));
      check($sformatf("tog%0d done", i),  32'(bus.frame_done), 32'(vecs[i].exp_done));
      check($sformatf("tog%0d busy", i),  32'(bus.busy),       32'(vecs[i].exp_busy));
    end
    bus.data_in_en = 1'b0;

    // start + load during streaming are ignored; next frame still sees 1.
    run_frame(1'b0, 5);
    run_frame(1'b0, -1);

    // Reset after pixel 7, then restart from pixel 1 with retained RAM.
    bus.start = 1'b1;
    step();
    bus.start      = 1'b0;
    bus.data_in_en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      step();
      check($sformatf("pre-rst px%0d data", k), 32'(bus.data), 32'(pix(k)));
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async reset");
    bus.data_in_en = 1'b0;
    #2 rst_n = 1'b1;
    step();
    check_idle_outputs("after reset");
    run_frame(1'b0, -1);

    // Requests in IDLE produce nothing and do not move the counters.
    bus.data_in_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("idle req%0d valid", i), 32'(bus.valid), 32'd0);
      check($sformatf("idle req%0d busy", i),  32'(bus.busy),  32'd0);
    end
    bus.data_in_en = 1'b0;
    run_frame(1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
